usb_cmd_frame_parser: RTL

- Sits directly downstream of the USB CDC receive path, in the PHY_CLK (60 MHz) domain.
- Consumes the raw byte stream usb_data/usb_data_valid and extracts framed commands.
- Frame format: 0xAA 0x55, cmd, len_h, len_l, payload[len], checksum.
- Streams payload bytes, with index, to the command handlers (PWM, UART, SPI, DAC, DSM), and flags success or failure at end of frame.

---
 rtl/usb_cmd_pkg.sv | 28 ++
 rtl/usb_frame_timeout.sv | 39 +++
 rtl/usb_cmd_frame_parser.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/usb_cmd_pkg.sv
// usb_cmd_pkg
// Shared definitions for the USB command frame parser and the CDC command
// handlers that consume its output stream.
//   - parse_state_t : frame parser state encoding
//   - DEFAULT_HEADER_0 / DEFAULT_HEADER_1 : default sync bytes (0xAA 0x55)
//   - CMD_* : command codes dispatched to the PWM/UART/SPI/DAC/DSM handlers
package usb_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_CMD   = 3'd2,
        ST_LEN_H = 3'd3,
        ST_LEN_L = 3'd4,
        ST_DATA  = 3'd5,
        ST_CHK   = 3'd6
    } parse_state_t;

    localparam logic [7:0] DEFAULT_HEADER_0 = 8'hAA;
    localparam logic [7:0] DEFAULT_HEADER_1 = 8'h55;

    localparam logic [7:0] CMD_PWM  = 8'h01;
    localparam logic [7:0] CMD_UART = 8'h02;
    localparam logic [7:0] CMD_SPI  = 8'h03;
    localparam logic [7:0] CMD_DAC  = 8'h04;
    localparam logic [7:0] CMD_DSM  = 8'h05;

endpackage

// File: rtl/usb_frame_timeout.sv
// usb_frame_timeout
// Inter-byte watchdog for the command frame parser. Only instantiated when
// FRAME_TIMEOUT_EN is defined.
// Ports:
//   clk    : PHY_CLK
//   rst    : asynchronous active-high reset
//   clear  : restart the count (a byte was received)
//   enable : count this cycle (a frame is in progress)
//   expire : high on the cycle the count reaches TIMEOUT_CYCLES-1
module usb_frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 6000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [22:0] LAST_COUNT = 23'(TIMEOUT_CYCLES - 1);

    logic [22:0] count;

    // Expiry does not depend on clear: a byte landing on the expiry cycle
    // still sees the frame abandoned and is evaluated from IDLE by the parser.
    assign expire = enable && (count == LAST_COUNT);

    // Count while a frame is open; any received byte or an expiry restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || expire) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 23'd1;
        end
    end

endmodule

// File: rtl/usb_cmd_frame_parser.sv
// usb_cmd_frame_parser
// Extracts framed commands (AA 55 cmd len_h len_l payload[len] checksum) from
// the USB CDC receive byte stream and streams the payload, with index, to the
// command handlers. Payload is not buffered: handlers must discard side
// effects when parse_error_o follows a frame.
// Optional: define FRAME_TIMEOUT_EN to abandon a stalled frame after
// TIMEOUT_CYCLES clocks without a byte (reported as parse_error_o).
// Ports:
//   clk, rst            : PHY_CLK, asynchronous active-high reset
//   usb_data_in/_valid  : received byte and its one-cycle strobe
//   cmd_type_out        : command code of the last accepted frame
//   cmd_length_out      : payload length of the last accepted frame
//   cmd_start_o         : pulse when header/cmd/len are accepted
//   cmd_data_out/_index : payload byte and its 0-based index
//   cmd_data_valid_o    : pulse per payload byte
//   cmd_done_o          : pulse when the checksum matches
//   parse_error_o       : pulse on checksum mismatch, oversize len or timeout
module usb_cmd_frame_parser
    import usb_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER_0       = DEFAULT_HEADER_0,
    parameter logic [7:0]  HEADER_1       = DEFAULT_HEADER_1,
    parameter int unsigned MAX_PAYLOAD    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 6000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic [7:0]  cmd_type_out,
    output logic [15:0] cmd_length_out,
    output logic        cmd_start_o,
    output logic [7:0]  cmd_data_out,
    output logic [15:0] cmd_data_index_out,
    output logic        cmd_data_valid_o,
    output logic        cmd_done_o,
    output logic        parse_error_o
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD);

    parse_state_t state, state_n, eval_state;
    logic [7:0]  sum, sum_n;
    logic [15:0] count, count_n;
    logic [15:0] len, len_n;
    logic [7:0]  cmd_reg, cmd_reg_n;
    logic [7:0]  len_h, len_h_n;
    logic [7:0]  type_n, data_n;
    logic [15:0] length_n, index_n;
    logic        start_n, valid_n, done_n, error_n;
    logic [15:0] rx_len;
    logic        frame_expire;

`ifdef FRAME_TIMEOUT_EN
    usb_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (usb_data_valid_in),
        .enable (state != ST_IDLE),
        .expire (frame_expire)
    );
`else
    // Without the watchdog a stalled frame waits forever; TIMEOUT_CYCLES is
    // still referenced so the parameter list is the same in both builds.
    assign frame_expire = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    assign rx_len = {len_h, usb_data_in};

    // Next-state and next-output logic. A timeout forces the frame closed and
    // the same-cycle byte (if any) is then judged as if the parser were idle.
    always_comb begin
        state_n   = state;
        sum_n     = sum;
        count_n   = count;
        len_n     = len;
        cmd_reg_n = cmd_reg;
        len_h_n   = len_h;
        type_n    = cmd_type_out;
        length_n  = cmd_length_out;
        data_n    = cmd_data_out;
        index_n   = cmd_data_index_out;
        start_n   = 1'b0;
        valid_n   = 1'b0;
        done_n    = 1'b0;
        error_n   = 1'b0;

        eval_state = state;
        if (frame_expire) begin
            eval_state = ST_IDLE;
            state_n    = ST_IDLE;
            error_n    = 1'b1;
        end

        if (usb_data_valid_in) begin
            case (eval_state)
                ST_IDLE: begin
                    if (usb_data_in == HEADER_0) state_n = ST_HDR1;
                end
                ST_HDR1: begin
                    if (usb_data_in == HEADER_1)      state_n = ST_CMD;
                    else if (usb_data_in == HEADER_0) state_n = ST_HDR1;
                    else                              state_n = ST_IDLE;
                end
                ST_CMD: begin
                    cmd_reg_n = usb_data_in;
                    sum_n     = usb_data_in;
                    state_n   = ST_LEN_H;
                end
                ST_LEN_H: begin
                    len_h_n = usb_data_in;
                    sum_n   = sum + usb_data_in;
                    state_n = ST_LEN_L;
                end
                ST_LEN_L: begin
                    sum_n = sum + usb_data_in;
                    if ({1'b0, rx_len} > MAX_LEN) begin
                        error_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        len_n    = rx_len;
                        type_n   = cmd_reg;
                        length_n = rx_len;
                        start_n  = 1'b1;
                        count_n  = '0;
                        state_n  = (rx_len == 16'd0) ? ST_CHK : ST_DATA;
                    end
                end
                ST_DATA: begin
                    data_n  = usb_data_in;
                    index_n = count;
                    valid_n = 1'b1;
                    sum_n   = sum + usb_data_in;
                    count_n = count + 16'd1;
                    if (count == len - 16'd1) state_n = ST_CHK;
                end
                ST_CHK: begin
                    if (usb_data_in == sum) done_n  = 1'b1;
                    else                    error_n = 1'b1;
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, accumulators and all outputs are registered together so every
    // response lands exactly one cycle after the byte that caused it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            sum                <= '0;
            count              <= '0;
            len                <= '0;
            cmd_reg            <= '0;
            len_h              <= '0;
            cmd_type_out       <= '0;
            cmd_length_out     <= '0;
            cmd_start_o        <= 1'b0;
            cmd_data_out       <= '0;
            cmd_data_index_out <= '0;
            cmd_data_valid_o   <= 1'b0;
            cmd_done_o         <= 1'b0;
            parse_error_o      <= 1'b0;
        end else begin
            state              <= state_n;
            sum                <= sum_n;
            count              <= count_n;
            len                <= len_n;
            cmd_reg            <= cmd_reg_n;
            len_h              <= len_h_n;
            cmd_type_out       <= type_n;
            cmd_length_out     <= length_n;
            cmd_start_o        <= start_n;
            cmd_data_out       <= data_n;
            cmd_data_index_out <= index_n;
            cmd_data_valid_o   <= valid_n;
            cmd_done_o         <= done_n;
            parse_error_o      <= error_n;
        end
    end

endmodule
